// File: rtl/mix_cols_seq_pkg.sv
// Shared types and constants for the MixColumns sequencer and its column unit.
// Includes the GF(2^8) doubling helper used by mix_cols.
package mix_cols_seq_pkg;

  localparam int COL_W    = 32;
  localparam int STATE_W  = 128;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/mix_cols_seq_cols.sv
// Combinational AES MixColumns transform for one 32-bit column.
// Row 0 is the most significant byte of the column.
module mix_cols
  import mix_cols_seq_pkg::*;
(
  input  logic [COL_W-1:0] input_col,
  output logic [COL_W-1:0] final_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0] w_d0, w_d1, w_d2, w_d3;

  assign w_a0 = input_col[31:24];
  assign w_a1 = input_col[23:16];
  assign w_a2 = input_col[15:8];
  assign w_a3 = input_col[7:0];

  assign w_d0 = xtime(w_a0);
  assign w_d1 = xtime(w_a1);
  assign w_d2 = xtime(w_a2);
  assign w_d3 = xtime(w_a3);

  // Each output byte is 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3).
  assign final_col[31:24] = w_d0 ^ (w_d1 ^ w_a1) ^ w_a2 ^ w_a3;
  assign final_col[23:16] = w_a0 ^ w_d1 ^ (w_d2 ^ w_a2) ^ w_a3;
  assign final_col[15:8]  = w_a0 ^ w_a1 ^ w_d2 ^ (w_d3 ^ w_a3);
  assign final_col[7:0]   = (w_d0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_d3;

endmodule

// File: rtl/mix_cols_seq.sv
// Time-shares one mix_cols unit across the four columns of an AES state.
// Define MIX_COLS_SEQ_BYPASS_EN to add the in_last port for last-round pass-through.
module mix_cols_seq
  import mix_cols_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
`ifdef MIX_COLS_SEQ_BYPASS_EN
  input  logic               in_last,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_col;
  logic [STATE_W-1:0] r_src;
  logic [STATE_W-1:0] r_res;
  logic [COL_W-1:0]   w_src_col;
  logic [COL_W-1:0]   w_mix_col;
  logic               w_accept;
  logic               w_to_done;

  assign w_accept = in_valid && in_ready;

`ifdef MIX_COLS_SEQ_BYPASS_EN
  assign w_to_done = in_last;
`else
  assign w_to_done = 1'b0;
`endif

  mix_cols u_mix_cols (
    .input_col (w_src_col),
    .final_col (w_mix_col)
  );

  always_comb begin
    w_src_col = r_src[127:96];
    case (r_col)
      2'd0:    w_src_col = r_src[127:96];
      2'd1:    w_src_col = r_src[95:64];
      2'd2:    w_src_col = r_src[63:32];
      default: w_src_col = r_src[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // in_ready in DONE follows out_ready so a new state can overlap the drain.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) begin
          w_next_state = w_to_done ? ST_DONE : ST_MIX;
        end
      end
      ST_MIX: begin
        busy = 1'b1;
        if (r_col == 2'd3) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (w_accept) begin
          w_next_state = w_to_done ? ST_DONE : ST_MIX;
        end else if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // The column counter parks at 3 and is only cleared by a new capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col <= 2'd0;
      r_src <= '0;
      r_res <= '0;
    end else if (w_accept) begin
      r_src <= in_state;
      r_col <= 2'd0;
      if (w_to_done) begin
        r_res <= in_state;
      end
    end else if (r_state == ST_MIX) begin
      case (r_col)
        2'd0:    r_res[127:96] <= w_mix_col;
        2'd1:    r_res[95:64]  <= w_mix_col;
        2'd2:    r_res[63:32]  <= w_mix_col;
        default: r_res[31:0]   <= w_mix_col;
      endcase
      if (r_col != 2'd3) begin
        r_col <= r_col + 2'd1;
      end
    end
  end

  assign out_state = r_res;

endmodule

// File: tb/tb_mix_cols_seq.sv
// Directed self-checking bench for mix_cols_seq using FIPS-197 MixColumns vectors.
// Define MIX_COLS_SEQ_BYPASS_EN to also exercise the last-round pass-through.
module tb_mix_cols_seq;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int errors;
  int checks;

  localparam logic [127:0] VEC_A_IN  = 128'hf5afc959_fbaa43f2_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_A_OUT = 128'h8ba938d0_b983da00_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B_IN  = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
  localparam logic [127:0] VEC_B_OUT = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;

  mix_cols_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef MIX_COLS_SEQ_BYPASS_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_state !== 128'h0) begin errors++; $display("[TB] FAIL reset_out_state got=%h want=0", out_state); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_after_reset in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_column();
    in_state = VEC_A_IN;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got=%b want=1", busy); end
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL single_early_E+%0d out_valid=%b in_ready=%b want 0/0", i, out_valid, in_ready);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency out_valid=%b want=1", out_valid); end
    checks++;
    if (out_state !== VEC_A_OUT) begin errors++; $display("[TB] FAIL single_state got=%h want=%h", out_state, VEC_A_OUT); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_done got=%b want=0", busy); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL single_drain out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_fips_vector();
    in_state = VEC_B_IN;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_state !== VEC_B_OUT) begin
      errors++; $display("[TB] FAIL fips_state valid=%b got=%h want=%h", out_valid, out_state, VEC_B_OUT);
    end
  endtask

  task automatic test_back_to_back();
    // Enters holding the FIPS result in DONE with out_ready low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_state !== VEC_B_OUT || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_%0d valid=%b in_ready=%b got=%h want=%h", i, out_valid, in_ready, out_state, VEC_B_OUT);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = VEC_A_IN;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_busy busy=%b out_valid=%b want 1/0", busy, out_valid);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_state !== VEC_A_OUT) begin
      errors++; $display("[TB] FAIL b2b_state valid=%b got=%h want=%h", out_valid, out_state, VEC_A_OUT);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mix();
    in_state = VEC_B_IN;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_ctrl out_valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
    end
    checks++;
    if (out_state !== 128'h0) begin errors++; $display("[TB] FAIL midreset_state got=%h want=0", out_state); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL midreset_quiet_%0d out_valid=%b busy=%b want 0/0", i, out_valid, busy);
      end
    end
  endtask

`ifdef MIX_COLS_SEQ_BYPASS_EN
  task automatic test_bypass();
    in_state = VEC_A_IN;
    in_last  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_state !== VEC_A_IN) begin
      errors++; $display("[TB] FAIL bypass valid=%b got=%h want=%h", out_valid, out_state, VEC_A_IN);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_column();
    test_fips_vector();
    test_back_to_back();
    test_reset_mid_mix();
`ifdef MIX_COLS_SEQ_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mix_cols_seq.md
# mix_cols_seq

Sequencer that time-shares one combinational `mix_cols` column unit across the four columns of a 128-bit AES state.
- Accepts a full state over a valid/ready handshake.
- Feeds one 32-bit column per cycle through the unit and assembles the mixed columns.
- Presents the 128-bit result over a second valid/ready handshake.
- Sits between the ShiftRows stage and AddRoundKey in the round datapath.

## Interface
- No parameters; widths are fixed by AES (state 128, column 32).
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_state` is valid.
- `in_ready` output 1: block can accept a state this cycle.
- `in_state` input 128: column 0 = [127:96], column 3 = [31:0]. Within a column, row 0 is the MSB byte.
- `in_last` input 1: final AES round; MixColumns is skipped. Present only with `MIX_COLS_SEQ_BYPASS_EN`.
- `out_valid` output 1: `out_state` holds a completed result.
- `out_ready` input 1: consumer takes the result this cycle.
- `out_state` output 128: mixed state, same column and byte order as `in_state`.
- `busy` output 1: high in MIX.

## Operation
- FSM states: IDLE, MIX, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`:
    - Capture `in_state` into the source register.
    - Clear the 2-bit column counter `col`.
    - Go to MIX. With `in_last`=1 (bypass build), instead copy the state straight to the result register and go to DONE.
- **MIX**
  - The `mix_cols` input is source column `col`.
  - Each edge writes the unit output into result column `col`, then `col` increments.
  - At `col`==3, the write completes and the FSM goes to DONE.
  - Input handshakes are ignored; `in_ready`=0.
- **DONE**
  - `out_valid`=1; `out_state` is stable until accepted.
  - On `out_ready` with no new input, go to IDLE.
  - `in_ready` = `out_ready`. A simultaneous input handshake captures the new state and goes directly to MIX (or DONE for bypass), with no IDLE bubble.
- `col` wraps 3→0 only via re-capture, never free-running.
- Reset mid-operation aborts the job; partial results are discarded.
- Result bytes are exactly those produced by `mix_cols` (GF(2^8) arithmetic, mod 0x11B); the sequencer adds no arithmetic.

## Timing
- Reset values:
  - state IDLE, `col`=0.
  - source and result registers all 0.
  - `out_valid`=0, `out_state`=0, `busy`=0, `in_ready`=1.
- Latency for a normal round:
  - Accept edge E.
  - Columns written at E+1…E+4.
  - `out_valid` is high in the cycle after E+4.
- Bypass latency: `out_valid` is high in the cycle after E.
- Throughput with `out_ready` held high: one state every 5 cycles (4 MIX + 1 DONE).
- `in_ready` and `out_valid` are decoded from the FSM state, not from combinational paths off `in_valid`. `in_ready` in DONE is the only combinational path: `out_ready`→`in_ready`.

## Configuration
- `MIX_COLS_SEQ_BYPASS_EN` defined:
  - The `in_last` port exists.
  - A last-round state passes through unmixed, with 1-cycle latency.
- `MIX_COLS_SEQ_BYPASS_EN` undefined:
  - There is no `in_last` port.
  - Every accepted state is mixed; bypass logic is not generated.

## Structure
- Shared package `mix_cols_seq_pkg`:
  - FSM state enum (IDLE/MIX/DONE).
  - `COL_W`=32, `STATE_W`=128, `NUM_COLS`=4.
- Sub-module: one instance of the existing `mix_cols` (`input_col`/`final_col`). No other sub-modules.

## Test plan
- Reset then idle: `reset_n` low → `out_valid`=0, `out_state`=0, `in_ready`=1, `busy`=0.
- Single column check:
  - Stimulus: `in_state`=f5afc959_fbaa43f2_01010101_c6c6c6c6.
  - Response: `out_state`=8ba938d0_b983da00_01010101_c6c6c6c6, `out_valid` high exactly 5 cycles after the accept edge.
- FIPS-197 vector:
  - Stimulus: db135345_f20a225c_d4d4d4d5_2d26314c.
  - Response: 8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8.
- Backpressure and back-to-back:
  - Hold `out_ready`=0 for 3 cycles in DONE → `out_state` stable and `in_ready`=0.
  - Then raise `out_ready` with `in_valid`=1 → new state accepted the same cycle and `busy`=1 the next cycle.
- Reset mid-MIX: assert `reset_n` low at `col`=2 → immediate IDLE, `out_valid`=0, no result emitted afterwards.
- Bypass (`MIX_COLS_SEQ_BYPASS_EN`): `in_last`=1 with f5afc959_… → `out_state` equals the input unchanged, `out_valid` high 1 cycle after accept.
